// File: rtl/btn_press_decoder.sv
// Button press decoder: classifies debounced press/release pulses into short,
// long, auto-repeat and double-press events.
module btn_press_decoder #(
    parameter int unsigned LONG_CYCLES   = 100_000_000,
    parameter int unsigned REPEAT_CYCLES = 25_000_000,
    parameter int unsigned DOUBLE_CYCLES = 30_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ondn,
    input  logic i_onup,
    output logic o_short,
    output logic o_long,
    output logic o_repeat,
    output logic o_double,
    output logic o_busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_HELD   = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_PRESS2 = 3'd4;

    // Terminal counts: the cycle before each threshold is reached.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [2:0]       state_r;
    logic [2:0]       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             cnt_clr_s;
    logic             short_s;
    logic             long_s;
    logic             repeat_s;
    logic             double_s;

    // Next-state, counter-clear and event-pulse decode.
    always_comb begin
        state_s   = state_r;
        cnt_clr_s = 1'b0;
        short_s   = 1'b0;
        long_s    = 1'b0;
        repeat_s  = 1'b0;
        double_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // The counter is parked at zero here so it can never wrap.
                cnt_clr_s = 1'b1;
                if (i_ondn) begin
                    state_s = ST_PRESS1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRESS1: begin
                if (i_onup) begin
                    state_s   = ST_GAP;
                    cnt_clr_s = 1'b1;
                end else if (cnt_r == LONG_LAST) begin
                    state_s   = ST_HELD;
                    cnt_clr_s = 1'b1;
                    long_s    = 1'b1;
                end else begin
                    state_s = ST_PRESS1;
                end
            end
            ST_HELD: begin
                if (i_onup) begin
                    state_s   = ST_IDLE;
                    cnt_clr_s = 1'b1;
                end else if (cnt_r == REPEAT_LAST) begin
                    state_s   = ST_HELD;
                    cnt_clr_s = 1'b1;
                    repeat_s  = 1'b1;
                end else begin
                    state_s = ST_HELD;
                end
            end
            ST_GAP: begin
                if (i_ondn) begin
                    state_s   = ST_PRESS2;
                    cnt_clr_s = 1'b1;
                end else if (cnt_r == DOUBLE_LAST) begin
                    state_s   = ST_IDLE;
                    cnt_clr_s = 1'b1;
                    short_s   = 1'b1;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_PRESS2: begin
                if (i_onup) begin
                    state_s   = ST_IDLE;
                    cnt_clr_s = 1'b1;
                    double_s  = 1'b1;
                end else if (cnt_r == LONG_LAST) begin
                    state_s   = ST_HELD;
                    cnt_clr_s = 1'b1;
                    long_s    = 1'b1;
                end else begin
                    state_s = ST_PRESS2;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            o_short  <= 1'b0;
            o_long   <= 1'b0;
            o_repeat <= 1'b0;
            o_double <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_clr_s ? {CNT_W{1'b0}} : (cnt_r + CNT_ONE);
            o_short  <= short_s;
            o_long   <= long_s;
            o_repeat <= repeat_s;
            o_double <= double_s;
            o_busy   <= (state_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_btn_press_decoder.sv
// Self-checking bench for btn_press_decoder: timestamp-based event model plus
// directed press/release scenarios with hand-computed pulse edges.
module tb_btn_press_decoder;

    localparam int LONG   = 20;
    localparam int REPEAT = 5;
    localparam int DOUBLE = 8;

    logic clk;
    logic rst;
    logic i_ondn;
    logic i_onup;
    logic o_short;
    logic o_long;
    logic o_repeat;
    logic o_double;
    logic o_busy;

    btn_press_decoder #(
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REPEAT),
        .DOUBLE_CYCLES(DOUBLE),
        .CNT_W        (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_ondn  (i_ondn),
        .i_onup  (i_onup),
        .o_short (o_short),
        .o_long  (o_long),
        .o_repeat(o_repeat),
        .o_double(o_double),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Event model: a button sequence is described by when the current press
    // started, when the last release happened and whether a long press fired.
    typedef struct {
        bit active;
        bit down;
        bit second;
        bit long_done;
        int t_down;
        int t_up;
        bit e_short;
        bit e_long;
        bit e_rep;
        bit e_dbl;
    } mdl_t;

    function automatic mdl_t mdl_idle();
        mdl_t r;
        r.active = 0; r.down = 0; r.second = 0; r.long_done = 0;
        r.t_down = 0; r.t_up = 0;
        r.e_short = 0; r.e_long = 0; r.e_rep = 0; r.e_dbl = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, int n, bit dn, bit up);
        mdl_t r = m;
        int el;
        r.e_short = 0; r.e_long = 0; r.e_rep = 0; r.e_dbl = 0;
        if (!m.active) begin
            if (dn) begin
                r.active = 1; r.down = 1; r.second = 0; r.long_done = 0; r.t_down = n;
            end
        end else if (m.down) begin
            el = n - m.t_down;
            if (up) begin
                if (m.long_done) r.active = 0;
                else if (m.second) begin r.e_dbl = 1; r.active = 0; end
                else begin r.down = 0; r.t_up = n; end
            end else if (!m.long_done) begin
                if (el == LONG) begin r.e_long = 1; r.long_done = 1; end
            end else if (((el - LONG) % REPEAT) == 0) begin
                r.e_rep = 1;
            end
        end else begin
            el = n - m.t_up;
            if (dn) begin r.down = 1; r.second = 1; r.t_down = n; end
            else if (el == DOUBLE) begin r.e_short = 1; r.active = 0; end
        end
        return r;
    endfunction

    mdl_t m_r;
    int   n_r;
    bit   chk_en;

    // Advance the model on every sampling edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r <= mdl_idle();
            n_r <= 0;
        end else begin
            m_r <= mdl_next(m_r, n_r, i_ondn, i_onup);
            n_r <= n_r + 1;
        end
    end

    // Compare every output against the model each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("short",  o_short,  m_r.e_short);
            chk("long",   o_long,   m_r.e_long);
            chk("repeat", o_repeat, m_r.e_rep);
            chk("double", o_double, m_r.e_dbl);
            chk("busy",   o_busy,   m_r.active);
            chk("onehot", int'($countones({o_short, o_long, o_repeat, o_double}) <= 1), 1);
        end
    end

    task automatic cyc(input bit dn, input bit up);
        i_ondn = dn;
        i_onup = up;
        @(negedge clk);
        i_ondn = 1'b0;
        i_onup = 1'b0;
    endtask

    int n_short, n_long, n_rep, n_dbl;
    int e_short, e_long, e_rep_first, e_rep_last, e_dbl;
    bit busy_h [0:63];

    // Run one scenario; event edges are relative to its first edge (-1 = none).
    task automatic scen(input int dn0, input int dn1, input int up0, input int up1, input int ncyc);
        n_short = 0; n_long = 0; n_rep = 0; n_dbl = 0;
        e_short = -1; e_long = -1; e_rep_first = -1; e_rep_last = -1; e_dbl = -1;
        for (int e = 0; e < ncyc; e++) begin
            cyc((e == dn0) || (e == dn1), (e == up0) || (e == up1));
            busy_h[e] = o_busy;
            if (o_short)  begin n_short++; e_short = e; end
            if (o_long)   begin n_long++;  e_long  = e; end
            if (o_double) begin n_dbl++;   e_dbl   = e; end
            if (o_repeat) begin
                if (n_rep == 0) e_rep_first = e;
                n_rep++;
                e_rep_last = e;
            end
        end
    endtask

    task automatic chk_short_seq(input string tag);
        scen(0, -1, 10, -1, 25);
        chk({tag, "_nshort"}, n_short, 1);
        chk({tag, "_eshort"}, e_short, 18);
        chk({tag, "_nother"}, n_long + n_rep + n_dbl, 0);
        chk({tag, "_busy0"},  busy_h[0], 1);
        chk({tag, "_busy17"}, busy_h[17], 1);
        chk({tag, "_busy18"}, busy_h[18], 0);
    endtask

    initial begin
        rst    = 1'b1;
        i_ondn = 1'b0;
        i_onup = 1'b0;
        chk_en = 1'b0;
        #1;
        chk("rst_outs", int'({o_short, o_long, o_repeat, o_double, o_busy}), 0);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;

        chk_short_seq("short");

        // Long hold with auto-repeat.
        scen(0, -1, 37, -1, 45);
        chk("hold_nlong", n_long, 1);
        chk("hold_elong", e_long, 20);
        chk("hold_nrep", n_rep, 3);
        chk("hold_rep_first", e_rep_first, 25);
        chk("hold_rep_last", e_rep_last, 35);
        chk("hold_nshort", n_short, 0);
        chk("hold_busy36", busy_h[36], 1);
        chk("hold_busy37", busy_h[37], 0);

        // Double press.
        scen(0, 9, 5, 12, 25);
        chk("dbl_n", n_dbl, 1);
        chk("dbl_e", e_dbl, 12);
        chk("dbl_nshort", n_short, 0);
        chk("dbl_busy12", busy_h[12], 0);

        // Release coincides with the long threshold.
        scen(0, -1, 20, -1, 35);
        chk("co1_nlong", n_long, 0);
        chk("co1_nshort", n_short, 1);
        chk("co1_eshort", e_short, 28);

        // Second press coincides with the window expiry.
        scen(0, 13, 5, 16, 30);
        chk("co2_nshort", n_short, 0);
        chk("co2_ndbl", n_dbl, 1);
        chk("co2_edbl", e_dbl, 16);

        // Press and release together while idle: the press is taken.
        scen(0, -1, 0, 4, 20);
        chk("both_nshort", n_short, 1);
        chk("both_eshort", e_short, 12);

        // Reset in the middle of a hold.
        scen(0, -1, -1, -1, 23);
        chk("rh_nlong", n_long, 1);
        chk("rh_busy_pre", o_busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("rh_outs", int'({o_short, o_long, o_repeat, o_double, o_busy}), 0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        scen(-1, -1, 0, -1, 12);
        chk("rh_stale_up", n_short + n_long + n_rep + n_dbl, 0);
        chk("rh_stale_busy", busy_h[0], 0);
        chk_short_seq("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
